// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// The typedefs describe the default 32 x 32-bit configuration.
package regfile_pkg;

   localparam int REGFILE_DATA_W = 32;
   localparam int REGFILE_DEPTH  = 32;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file.
// Selects, in priority order: the hardwired zero register, same-cycle writeback data, or the stored value.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REGFILE_DATA_W,
   parameter int DEPTH    = REGFILE_DEPTH,
   parameter int ADDR_W   = $clog2(REGFILE_DEPTH),
   parameter bit ZERO_REG = 1'b1
)(
   input  logic [ADDR_W-1:0]             rs_addr_i,
   input  logic                          rd_wren_i,
   input  logic [ADDR_W-1:0]             rd_addr_i,
   input  logic [DATA_W-1:0]             rd_data_i,
   input  logic [DEPTH-1:0][DATA_W-1:0]  mem_i,
   input  logic [DEPTH-1:0]              busy_i,
   output logic [DATA_W-1:0]             rs_data_o,
   output logic                          rs_busy_o
);

   logic is_zero;
   logic bypass_hit;

   assign is_zero    = ZERO_REG && (rs_addr_i == '0);
   assign bypass_hit = rd_wren_i && (rd_addr_i == rs_addr_i);

   // A bypassed writeback also resolves the hazard, so busy is masked on a bypass hit.
   always_comb begin
      rs_data_o = '0;
      rs_busy_o = 1'b0;
      if (is_zero) begin
         rs_data_o = '0;
         rs_busy_o = 1'b0;
      end else if (bypass_hit) begin
         rs_data_o = rd_data_i;
         rs_busy_o = 1'b0;
      end else begin
         rs_data_o = mem_i[rs_addr_i];
         rs_busy_o = busy_i[rs_addr_i];
      end
   end

endmodule : regfile_rdport

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-to-read bypass.
// Also keeps a per-register busy scoreboard so decode can detect RAW hazards.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int   DATA_W   = REGFILE_DATA_W,
   parameter int   DEPTH    = REGFILE_DEPTH,
   parameter int   NUM_RD   = 2,
   parameter bit   ZERO_REG = 1'b1,
   localparam int  ADDR_W   = $clog2(DEPTH)
)(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       rd_wren_i,
   input  logic [ADDR_W-1:0]          rd_addr_i,
   input  logic [DATA_W-1:0]          rd_data_i,
   input  logic [NUM_RD*ADDR_W-1:0]   rs_addr_i,
   output logic [NUM_RD*DATA_W-1:0]   rs_data_o,
   output logic [NUM_RD-1:0]          rs_busy_o,
   input  logic                       issue_valid_i,
   input  logic [ADDR_W-1:0]          issue_rd_i,
   output logic [DEPTH-1:0]           busy_vec_o
);

   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [DEPTH-1:0]             busy_q, busy_d;

   // Next-state for storage: writes to the hardwired zero register are dropped.
   always_comb begin
      mem_d = mem_q;
      if (rd_wren_i && !(ZERO_REG && (rd_addr_i == '0))) begin
         mem_d[rd_addr_i] = rd_data_i;
      end else begin
         mem_d = mem_q;
      end
   end

   // Scoreboard next-state: a new issue to the same register outranks its completing writeback.
   always_comb begin
      busy_d = busy_q;
      for (int a = 0; a < DEPTH; a++) begin
         if (ZERO_REG && (a == 0)) begin
            busy_d[a] = 1'b0;
         end else if (issue_valid_i && (issue_rd_i == ADDR_W'(a))) begin
            busy_d[a] = 1'b1;
         end else if (rd_wren_i && (rd_addr_i == ADDR_W'(a))) begin
            busy_d[a] = 1'b0;
         end else begin
            busy_d[a] = busy_q[a];
         end
      end
   end

   // State registers; reset clears data and scoreboard asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q  <= '0;
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec_o = busy_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_rdport #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_rdport (
         .rs_addr_i (rs_addr_i[k*ADDR_W +: ADDR_W]),
         .rd_wren_i (rd_wren_i),
         .rd_addr_i (rd_addr_i),
         .rd_data_i (rd_data_i),
         .mem_i     (mem_q),
         .busy_i    (busy_q),
         .rs_data_o (rs_data_o[k*DATA_W +: DATA_W]),
         .rs_busy_o (rs_busy_o[k])
      );
   end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance (A) and a 4-port/16-deep/64-bit/no-zero-reg instance (B),
// both compared against array-based reference models.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst_n;

   logic        wren_a, iv_a;
   logic [4:0]  waddr_a, ird_a;
   logic [31:0] wdata_a, bvec_a;
   logic [9:0]  rsaddr_a;
   logic [63:0] rsdata_a;
   logic [1:0]  rsbusy_a;

   logic         wren_b, iv_b;
   logic [3:0]   waddr_b, ird_b;
   logic [63:0]  wdata_b;
   logic [15:0]  rsaddr_b, bvec_b;
   logic [255:0] rsdata_b;
   logic [3:0]   rsbusy_b;

   logic [31:0] ma [32];
   logic        ba [32];
   logic [63:0] mb [16];
   logic        bb [16];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   regfile_mp u_dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .rd_wren_i(wren_a), .rd_addr_i(waddr_a), .rd_data_i(wdata_a),
      .rs_addr_i(rsaddr_a), .rs_data_o(rsdata_a), .rs_busy_o(rsbusy_a),
      .issue_valid_i(iv_a), .issue_rd_i(ird_a), .busy_vec_o(bvec_a)
   );

   regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4), .ZERO_REG(1'b0)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .rd_wren_i(wren_b), .rd_addr_i(waddr_b), .rd_data_i(wdata_b),
      .rs_addr_i(rsaddr_b), .rs_data_o(rsdata_b), .rs_busy_o(rsbusy_b),
      .issue_valid_i(iv_b), .issue_rd_i(ird_b), .busy_vec_o(bvec_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_da(input logic [4:0] ad);
      if (ad == 5'd0) return 32'd0;
      if (wren_a && waddr_a == ad) return wdata_a;
      return ma[ad];
   endfunction

   function automatic logic exp_ba(input logic [4:0] ad);
      if (ad == 5'd0) return 1'b0;
      return ba[ad] && !(wren_a && waddr_a == ad);
   endfunction

   function automatic logic [63:0] exp_db(input logic [3:0] ad);
      if (wren_b && waddr_b == ad) return wdata_b;
      return mb[ad];
   endfunction

   function automatic logic exp_bb(input logic [3:0] ad);
      return bb[ad] && !(wren_b && waddr_b == ad);
   endfunction

   task automatic clr_model();
      for (int i = 0; i < 32; i++) begin ma[i] = 32'd0; ba[i] = 1'b0; end
      for (int i = 0; i < 16; i++) begin mb[i] = 64'd0; bb[i] = 1'b0; end
   endtask

   // Reference update for one rising edge: write lands, writeback clears, issue then (re)marks busy.
   task automatic upd_model();
      if (wren_a && waddr_a != 5'd0) ma[waddr_a] = wdata_a;
      if (wren_a) ba[waddr_a] = 1'b0;
      if (iv_a && ird_a != 5'd0) ba[ird_a] = 1'b1;
      if (wren_b) mb[waddr_b] = wdata_b;
      if (wren_b) bb[waddr_b] = 1'b0;
      if (iv_b) bb[ird_b] = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) upd_model();
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] ev_a;
      logic [15:0] ev_b;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s a%0d data", tag, k), {32'd0, rsdata_a[k*32 +: 32]}, {32'd0, exp_da(rsaddr_a[k*5 +: 5])});
         chk($sformatf("%s a%0d busy", tag, k), {63'd0, rsbusy_a[k]}, {63'd0, exp_ba(rsaddr_a[k*5 +: 5])});
      end
      for (int i = 0; i < 32; i++) ev_a[i] = ba[i];
      chk($sformatf("%s a busy_vec", tag), {32'd0, bvec_a}, {32'd0, ev_a});
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s b%0d data", tag, k), rsdata_b[k*64 +: 64], exp_db(rsaddr_b[k*4 +: 4]));
         chk($sformatf("%s b%0d busy", tag, k), {63'd0, rsbusy_b[k]}, {63'd0, exp_bb(rsaddr_b[k*4 +: 4])});
      end
      for (int i = 0; i < 16; i++) ev_b[i] = bb[i];
      chk($sformatf("%s b busy_vec", tag), {48'd0, bvec_b}, {48'd0, ev_b});
   endtask

   initial begin
      rst_n = 1'b0;
      wren_a = 1'b0; iv_a = 1'b0; waddr_a = 5'd0; ird_a = 5'd0; wdata_a = 32'd0; rsaddr_a = 10'd0;
      wren_b = 1'b0; iv_b = 1'b0; waddr_b = 4'd0; ird_b = 4'd0; wdata_b = 64'd0; rsaddr_b = 16'd0;
      clr_model();
      #2;
      check_all("reset");
      #2 rst_n = 1'b1;

      // Mid-cycle asynchronous reset after a write to reg2 and an issue to reg3
      wren_a = 1'b1; waddr_a = 5'd2; wdata_a = 32'hF; iv_a = 1'b1; ird_a = 5'd3;
      rsaddr_a = {5'd3, 5'd2};
      tick();
      wren_a = 1'b0; iv_a = 1'b0;
      #1 check_all("pre-rst");
      chk("pre-rst busy3", {63'd0, bvec_a[3]}, 64'd1);
      #1 rst_n = 1'b0;
      clr_model();
      #1 check_all("async-rst");
      chk("async-rst data0", {32'd0, rsdata_a[31:0]}, 64'd0);
      chk("async-rst busy_vec", {32'd0, bvec_a}, 64'd0);
      #1 rst_n = 1'b1;
      tick();
      chk("post-rst reg2", {32'd0, rsdata_a[31:0]}, 64'd0);

      // Write then read
      wren_a = 1'b1; waddr_a = 5'd2; wdata_a = 32'h0000_000F;
      tick();
      wren_a = 1'b0; rsaddr_a = {5'd3, 5'd2};
      #1 check_all("wr-rd");
      chk("wr-rd p0", {32'd0, rsdata_a[31:0]}, 64'hF);
      chk("wr-rd p1", {32'd0, rsdata_a[63:32]}, 64'd0);
      wren_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hA;
      tick();
      wren_a = 1'b0;
      #1 chk("wr-rd reg3", {32'd0, rsdata_a[63:32]}, 64'hA);

      // Bypass
      wren_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h1234; rsaddr_a = {5'd2, 5'd5};
      #1 check_all("bypass");
      chk("bypass same-cycle", {32'd0, rsdata_a[31:0]}, 64'h1234);
      tick();
      wren_a = 1'b0;
      #1 chk("bypass after", {32'd0, rsdata_a[31:0]}, 64'h1234);

      // Zero register
      wren_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hDEAD_BEEF; iv_a = 1'b1; ird_a = 5'd0;
      rsaddr_a = {5'd0, 5'd0};
      #1 check_all("zero");
      chk("zero same-cycle", {32'd0, rsdata_a[31:0]}, 64'd0);
      tick();
      wren_a = 1'b0; iv_a = 1'b0;
      #1 chk("zero next", {32'd0, rsdata_a[31:0]}, 64'd0);
      chk("zero busy0", {63'd0, bvec_a[0]}, 64'd0);

      // Scoreboard set and clear
      iv_a = 1'b1; ird_a = 5'd7; rsaddr_a = {5'd2, 5'd7};
      tick();
      iv_a = 1'b0;
      #1 check_all("sb-set");
      chk("sb busy7", {63'd0, rsbusy_a[0]}, 64'd1);
      tick();
      wren_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h55;
      #1 check_all("sb-wb");
      chk("sb wb busy", {63'd0, rsbusy_a[0]}, 64'd0);
      chk("sb wb data", {32'd0, rsdata_a[31:0]}, 64'h55);
      tick();
      wren_a = 1'b0;
      #1 chk("sb cleared", {63'd0, bvec_a[7]}, 64'd0);

      // Simultaneous issue + writeback while busy
      iv_a = 1'b1; ird_a = 5'd7;
      tick();
      wren_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h77;
      #1 check_all("simul");
      tick();
      wren_a = 1'b0; iv_a = 1'b0;
      #1 check_all("simul-after");
      chk("simul busy7", {63'd0, bvec_a[7]}, 64'd1);
      chk("simul data", {32'd0, rsdata_a[31:0]}, 64'h77);

      // Wide configuration without a zero register
      wren_b = 1'b1; waddr_b = 4'd0; wdata_b = 64'hFFFF_FFFF_0000_0001; rsaddr_b = 16'd0;
      #1 check_all("b-reg0-byp");
      tick();
      wren_b = 1'b0;
      #1 check_all("b-reg0");
      for (int k = 0; k < 4; k++)
         chk($sformatf("b reg0 port%0d", k), rsdata_b[k*64 +: 64], 64'hFFFF_FFFF_0000_0001);

      // Randomised traffic on both instances
      for (int n = 0; n < 400; n++) begin
         wren_a = 1'($urandom_range(0, 1)); waddr_a = 5'($urandom_range(0, 7));
         wdata_a = $urandom; iv_a = 1'($urandom_range(0, 1)); ird_a = 5'($urandom_range(0, 7));
         rsaddr_a = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wren_b = 1'($urandom_range(0, 1)); waddr_b = 4'($urandom_range(0, 15));
         wdata_b = {$urandom, $urandom}; iv_b = 1'($urandom_range(0, 1)); ird_b = 4'($urandom_range(0, 15));
         for (int k = 0; k < 4; k++) rsaddr_b[k*4 +: 4] = 4'($urandom_range(0, 15));
         #1 check_all($sformatf("rand%0d", n));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the 32x32 two-read/one-write pipeline register file.
- Adds a configurable number of read ports, configurable data width and depth, and write-to-read bypass (same-cycle writeback visible on reads).
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards on in-flight destinations.
- Sits between decode (read + issue) and writeback (write + busy clear) in the pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of architectural registers; must be a power of 2 and >= 2.
- ADDR_W, $clog2(DEPTH), register address width; derived, not overridden.
- NUM_RD, 2, number of read ports; range 1..4.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rd_wren_i  in  1  writeback enable.
- rd_addr_i  in  ADDR_W  writeback destination address.
- rd_data_i  in  DATA_W  writeback data.
- rs_addr_i  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rs_data_o  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
- rs_busy_o  out  NUM_RD  per-port flag: the addressed register has a pending writer.
- issue_valid_i  in  1  decode issues an instruction that will write issue_rd_i.
- issue_rd_i  in  ADDR_W  destination of the issuing instruction.
- busy_vec_o  out  DEPTH  raw scoreboard bits, for debug and assertions.

Behaviour:
- Reset (rst_ni=0, asynchronous): all registers clear to 0 and all busy bits clear to 0.
  - Outputs follow combinationally: rs_data_o=0, rs_busy_o=0, busy_vec_o=0.
  - Reset asserted mid-operation discards any in-progress write or issue on that edge.
- Write: at posedge, when rd_wren_i=1, reg[rd_addr_i] <= rd_data_i.
  - A write to address 0 is ignored when ZERO_REG=1.
- Read: combinational, zero latency, all ports independent.
  - If ZERO_REG=1 and the address is 0, data is 0.
  - Else if rd_wren_i=1 and rd_addr_i equals the port address, data is rd_data_i (bypass).
  - Else data is reg[addr].
- Scoreboard update at posedge, evaluated per register a (a≠0 when ZERO_REG=1):
  - set_a = issue_valid_i && issue_rd_i==a
  - clr_a = rd_wren_i && rd_addr_i==a
  - set_a=1 wins over clr_a=1: a new producer supersedes the completing one, so busy[a] stays 1.
  - Otherwise clr_a=1 gives busy[a] <= 0; otherwise busy[a] holds.
- rs_busy_o[k] = busy[addr_k] && !(rd_wren_i && rd_addr_i==addr_k).
  - The same-cycle writeback resolves the hazard because the data is bypassed.
  - Always 0 for address 0 when ZERO_REG=1.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- Multiple read ports may address the same register; each returns identical data.
- busy_vec_o = busy bits. Bit 0 is constant 0 when ZERO_REG=1.
- Write data width is exactly DATA_W; no sign or zero extension occurs inside the block.

Decomposition:
- Package regfile_pkg holds:
  - default constants REGFILE_DATA_W=32, REGFILE_DEPTH=32;
  - typedef reg_addr_t (logic [4:0]);
  - typedef reg_data_t (logic [31:0]).
- Sub-module regfile_rdport (one instance per read port via generate) holds the zero-register / bypass / array select and the busy masking logic.
- Storage array and scoreboard stay in the top module.

Test Plan:
- Reset: drive rst_ni=0 mid-cycle after writes of 0xF to reg2 and issue to reg3 -> immediately rs_data_o=0 on all ports and busy_vec_o=0; after release, reading reg2 returns 0.
- Write then read: write reg2=0x0000000F at edge, then set rs_addr port0=2, port1=3 -> port0=0xF, port1=0; next write reg3=0xA -> port1=0xA.
- Bypass: rd_wren_i=1, rd_addr_i=5, rd_data_i=0x1234 with port0 addressing 5 in the same cycle -> rs_data_o port0=0x1234 before the edge, and still 0x1234 after the edge with rd_wren_i=0.
- Zero register: write 0xDEADBEEF to addr 0 with issue_rd_i=0 -> reads of addr 0 return 0 both same cycle and next cycle; busy_vec_o[0]=0.
- Scoreboard: issue reg7 -> next cycle rs_busy_o=1 on the port reading 7; writeback reg7=0x55 in a later cycle -> rs_busy_o=0 in that same cycle, data=0x55; busy_vec_o[7]=0 after the edge.
- Simultaneous issue+writeback to reg7 while busy -> busy_vec_o[7] stays 1 after the edge and reg7 holds the written data.
- Parameter sweep: NUM_RD=4, DEPTH=16, DATA_W=64, ZERO_REG=0 -> write 0xFFFF_FFFF_0000_0001 to reg0 and read it back on all 4 ports; each port returns the written value.
